vx_csr_pid_sequencer: RTL and testbench

//  Sequences one full-warp CSR access (NUM_THREADS lanes) onto the narrower SFU CSR port (NUM_LANES lanes/cycle).

---
 rtl/vx_csr_seq_pkg.sv | 28 ++
 rtl/vx_csr_pkt_select.sv | 39 +++
 rtl/vx_csr_pid_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_vx_csr_pid_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_csr_seq_pkg.sv
// Shared types and helpers for the warp-to-port CSR pid sequencer.
package vx_csr_seq_pkg;

    localparam int UUID_W_DEF = 44;
    localparam int NW_W_DEF   = 2;
    localparam int ADDR_W_DEF = 12;
    localparam int XLEN_DEF   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RSP   = 2'd2
    } seq_state_t;

    // Index width that stays at least one bit wide for single-packet configs.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int num_packets(input int threads, input int lanes);
        return threads / lanes;
    endfunction

    function automatic int slice_base(input int pid, input int lanes);
        return pid * lanes;
    endfunction

endpackage

// File: rtl/vx_csr_pkt_select.sv
// Finds the lowest packet with a non-empty tmask slice, either from 0 (first) or strictly above cur_pid.
// Purely combinational, zero latency, no flow control.
import vx_csr_seq_pkg::*;

module vx_csr_pkt_select #(
    parameter  int NUM_THREADS = 8,
    parameter  int NUM_LANES   = 4,
    localparam int NUM_PACKETS = num_packets(NUM_THREADS, NUM_LANES),
    localparam int PID_WIDTH   = log2up(NUM_PACKETS)
) (
    input  logic [NUM_THREADS-1:0] tmask,
    input  logic [PID_WIDTH-1:0]   cur_pid,
    input  logic                   first,
    output logic [PID_WIDTH-1:0]   next_pid,
    output logic                   found
);

    logic [NUM_PACKETS-1:0] pkt_active;

    always_comb begin
        pkt_active = '0;
        for (int p = 0; p < NUM_PACKETS; p++) begin
            pkt_active[p] = |tmask[slice_base(p, NUM_LANES) +: NUM_LANES];
        end
    end

    // Walk downward so the lowest qualifying packet wins.
    always_comb begin
        next_pid = '0;
        found    = 1'b0;
        for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
            if (pkt_active[p] && (first || (p > int'(cur_pid)))) begin
                next_pid = PID_WIDTH'(p);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_csr_pid_sequencer.sv
// Splits one full-warp CSR access into per-packet CSR port accesses and gathers read data into a warp response.
// Latency accept->rsp_valid = active packets + 1 cycle; one request in flight, req_ready low until rsp handshake.
import vx_csr_seq_pkg::*;

module vx_csr_pid_sequencer #(
    parameter  int NUM_THREADS = 8,
    parameter  int NUM_LANES   = 4,
    parameter  int UUID_W      = UUID_W_DEF,
    parameter  int NW_W        = NW_W_DEF,
    parameter  int ADDR_W      = ADDR_W_DEF,
    parameter  int XLEN        = XLEN_DEF,
    localparam int NUM_PACKETS = num_packets(NUM_THREADS, NUM_LANES),
    localparam int PID_WIDTH   = log2up(NUM_PACKETS)
) (
    input  logic                        clk,
    input  logic                        reset_n,

    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [UUID_W-1:0]           req_uuid,
    input  logic [NW_W-1:0]             req_wid,
    input  logic [NUM_THREADS-1:0]      req_tmask,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic                        req_rd,
    input  logic                        req_wr,
    input  logic [NUM_THREADS*XLEN-1:0] req_data,

    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [UUID_W-1:0]           rsp_uuid,
    output logic [NW_W-1:0]             rsp_wid,
    output logic [NUM_THREADS-1:0]      rsp_tmask,
    output logic [NUM_THREADS*XLEN-1:0] rsp_data,

    output logic                        csr_read_enable,
    output logic                        csr_write_enable,
    output logic [UUID_W-1:0]           csr_uuid,
    output logic [NW_W-1:0]             csr_wid,
    output logic [NUM_LANES-1:0]        csr_tmask,
    output logic [PID_WIDTH-1:0]        csr_pid,
    output logic [ADDR_W-1:0]           csr_addr,
    output logic [NUM_LANES*XLEN-1:0]   csr_write_data,
    input  logic [NUM_LANES*XLEN-1:0]   csr_read_data
);

    seq_state_t                  state, state_nxt;
    logic [PID_WIDTH-1:0]        pid, pid_nxt;

    logic [UUID_W-1:0]           uuid_q;
    logic [NW_W-1:0]             wid_q;
    logic [NUM_THREADS-1:0]      tmask_q;
    logic [ADDR_W-1:0]           addr_q;
    logic                        rd_q;
    logic                        wr_q;
    logic [NUM_THREADS*XLEN-1:0] data_q;
    logic [NUM_THREADS*XLEN-1:0] rsp_buf;

    logic [NUM_THREADS-1:0]      sel_tmask;
    logic                        sel_first;
    logic [PID_WIDTH-1:0]        sel_pid;
    logic                        sel_found;
    logic                        accept;

    // In IDLE the finder looks at the incoming mask to pick the first packet.
    assign sel_first = (state == IDLE);
    assign sel_tmask = sel_first ? req_tmask : tmask_q;
    assign accept    = (state == IDLE) && req_valid;

    vx_csr_pkt_select #(
        .NUM_THREADS (NUM_THREADS),
        .NUM_LANES   (NUM_LANES)
    ) u_pkt_select (
        .tmask    (sel_tmask),
        .cur_pid  (pid),
        .first    (sel_first),
        .next_pid (sel_pid),
        .found    (sel_found)
    );

    always_comb begin
        state_nxt        = state;
        pid_nxt          = pid;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        csr_read_enable  = 1'b0;
        csr_write_enable = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!sel_found || (!req_rd && !req_wr)) begin
                        pid_nxt   = '0;
                        state_nxt = RSP;
                    end else begin
                        pid_nxt   = sel_pid;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                csr_read_enable  = rd_q;
                csr_write_enable = wr_q;
                if (sel_found) begin
                    pid_nxt = sel_pid;
                end else begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                    pid_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                pid_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pid   <= '0;
        end else begin
            state <= state_nxt;
            pid   <= pid_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uuid_q  <= '0;
            wid_q   <= '0;
            tmask_q <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            rsp_buf <= '0;
        end else if (accept) begin
            uuid_q  <= req_uuid;
            wid_q   <= req_wid;
            tmask_q <= req_tmask;
            addr_q  <= req_addr;
            rd_q    <= req_rd;
            wr_q    <= req_wr;
            data_q  <= req_data;
            rsp_buf <= '0;
        end else if ((state == ISSUE) && rd_q) begin
            // Slave read data is the pre-write value, captured on the same edge the write commits.
            for (int p = 0; p < NUM_PACKETS; p++) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if ((pid == PID_WIDTH'(p)) && tmask_q[slice_base(p, NUM_LANES) + l]) begin
                        rsp_buf[(slice_base(p, NUM_LANES) + l)*XLEN +: XLEN] <= csr_read_data[l*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_comb begin
        csr_tmask      = '0;
        csr_write_data = '0;
        if (state == ISSUE) begin
            for (int p = 0; p < NUM_PACKETS; p++) begin
                if (pid == PID_WIDTH'(p)) begin
                    csr_tmask      = tmask_q[slice_base(p, NUM_LANES) +: NUM_LANES];
                    csr_write_data = data_q[slice_base(p, NUM_LANES)*XLEN +: NUM_LANES*XLEN];
                end
            end
        end
    end

    assign csr_uuid  = uuid_q;
    assign csr_wid   = wid_q;
    assign csr_pid   = pid;
    assign csr_addr  = addr_q;

    assign rsp_uuid  = uuid_q;
    assign rsp_wid   = wid_q;
    assign rsp_tmask = tmask_q;
    assign rsp_data  = rsp_buf;

endmodule

// File: tb/tb_vx_csr_pid_sequencer.sv
// Directed bench for the CSR pid sequencer with a combinational slave returning pid*16+lane.
module tb_vx_csr_pid_sequencer;

    localparam int NT = 8;
    localparam int NL = 4;
    localparam int XL = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [43:0]      req_uuid;
    logic [1:0]       req_wid;
    logic [NT-1:0]    req_tmask;
    logic [11:0]      req_addr;
    logic             req_rd;
    logic             req_wr;
    logic [NT*XL-1:0] req_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [43:0]      rsp_uuid;
    logic [1:0]       rsp_wid;
    logic [NT-1:0]    rsp_tmask;
    logic [NT*XL-1:0] rsp_data;
    logic             csr_read_enable;
    logic             csr_write_enable;
    logic [43:0]      csr_uuid;
    logic [1:0]       csr_wid;
    logic [NL-1:0]    csr_tmask;
    logic [0:0]       csr_pid;
    logic [11:0]      csr_addr;
    logic [NL*XL-1:0] csr_write_data;
    logic [NL*XL-1:0] csr_read_data;

    int n_vec = 0;
    int n_bad = 0;

    int               n_rd;
    int               n_wr;
    logic [1:0]       rd_pid_mask;
    logic [0:0]       wr_pid;
    logic [NL-1:0]    wr_tmask;
    logic [NL*XL-1:0] wr_data;
    logic [11:0]      wr_addr;

    always #5 clk = ~clk;

    vx_csr_pid_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_uuid         (req_uuid),
        .req_wid          (req_wid),
        .req_tmask        (req_tmask),
        .req_addr         (req_addr),
        .req_rd           (req_rd),
        .req_wr           (req_wr),
        .req_data         (req_data),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_uuid         (rsp_uuid),
        .rsp_wid          (rsp_wid),
        .rsp_tmask        (rsp_tmask),
        .rsp_data         (rsp_data),
        .csr_read_enable  (csr_read_enable),
        .csr_write_enable (csr_write_enable),
        .csr_uuid         (csr_uuid),
        .csr_wid          (csr_wid),
        .csr_tmask        (csr_tmask),
        .csr_pid          (csr_pid),
        .csr_addr         (csr_addr),
        .csr_write_data   (csr_write_data),
        .csr_read_data    (csr_read_data)
    );

    always_comb begin
        csr_read_data = '0;
        for (int l = 0; l < NL; l++) begin
            csr_read_data[l*XL +: XL] = 32'(csr_pid) * 32'd16 + 32'(l);
        end
    end

    always @(posedge clk) begin
        if (csr_read_enable) begin
            n_rd++;
            rd_pid_mask[csr_pid] = 1'b1;
        end
        if (csr_write_enable) begin
            n_wr++;
            wr_pid   = csr_pid;
            wr_tmask = csr_tmask;
            wr_data  = csr_write_data;
            wr_addr  = csr_addr;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        n_rd        = 0;
        n_wr        = 0;
        rd_pid_mask = '0;
        wr_pid      = '0;
        wr_tmask    = '0;
        wr_data     = '0;
        wr_addr     = '0;
    endtask

    task automatic drive(input logic [NT-1:0] tm, input logic rd, input logic wr,
                         input logic [NT*XL-1:0] d, input logic [43:0] uuid, input logic [11:0] addr);
        req_tmask = tm;
        req_rd    = rd;
        req_wr    = wr;
        req_data  = d;
        req_uuid  = uuid;
        req_wid   = 2'd2;
        req_addr  = addr;
        req_valid = 1'b1;
    endtask

    // Called at the negedge after acceptance; returns cycles from accept to rsp_valid.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_hs_rsp_valid", rsp_valid, 1'b0);
        check("post_hs_req_ready", req_ready, 1'b1);
    endtask

    initial begin
        int lat;
        logic [NT*XL-1:0] snap;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        drive('0, 1'b0, 1'b0, '0, '0, '0);
        req_valid = 1'b0;
        clr_mon();
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_strobes", {csr_read_enable, csr_write_enable}, 2'b00);
        check("rst_rsp_data", rsp_data, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Full-warp read: both packets issued.
        check("t1_req_ready", req_ready, 1'b1);
        clr_mon();
        drive(8'hFF, 1'b1, 1'b0, '0, 44'h123, 12'hCC0);
        @(negedge clk);
        req_valid = 1'b0;
        check("t1_issue_pid0", {csr_read_enable, csr_write_enable, csr_pid}, 3'b100);
        check("t1_issue_addr", csr_addr, 12'hCC0);
        wait_rsp(lat);
        check("t1_latency", lat, 3);
        check("t1_n_rd", n_rd, 2);
        check("t1_n_wr", n_wr, 0);
        check("t1_rd_pids", rd_pid_mask, 2'b11);
        check("t1_rsp_data", rsp_data,
              256'h00000013_00000012_00000011_00000010_00000003_00000002_00000001_00000000);
        check("t1_lane5", rsp_data[5*XL +: XL], 32'h11);
        check("t1_rsp_uuid", rsp_uuid, 44'h123);
        check("t1_rsp_wid", rsp_wid, 2'd2);
        check("t1_rsp_tmask", rsp_tmask, 8'hFF);
        check("t1_req_ready_rsp", req_ready, 1'b0);
        finish_rsp();

        // Upper packet only, read+write.
        clr_mon();
        drive(8'hF0, 1'b1, 1'b1,
              256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0,
              44'h456, 12'h300);
        @(negedge clk);
        req_valid = 1'b0;
        check("t2_issue_tmask", csr_tmask, 4'hF);
        wait_rsp(lat);
        check("t2_latency", lat, 2);
        check("t2_n_rd", n_rd, 1);
        check("t2_n_wr", n_wr, 1);
        check("t2_rd_pids", rd_pid_mask, 2'b10);
        check("t2_wr_pid", wr_pid, 1'b1);
        check("t2_wr_tmask", wr_tmask, 4'hF);
        check("t2_wr_data", wr_data, 128'h000000A7_000000A6_000000A5_000000A4);
        check("t2_wr_addr", wr_addr, 12'h300);
        check("t2_rsp_data", rsp_data,
              256'h00000013_00000012_00000011_00000010_00000000_00000000_00000000_00000000);
        finish_rsp();

        // Empty mask: straight to response.
        clr_mon();
        drive(8'h00, 1'b1, 1'b0, '1, 44'h789, 12'hCC0);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat);
        check("t3_latency", lat, 1);
        check("t3_strobes", n_rd + n_wr, 0);
        check("t3_rsp_data", rsp_data, '0);
        check("t3_rsp_tmask", rsp_tmask, 8'h00);
        finish_rsp();

        // Response stall with a second request already waiting.
        clr_mon();
        drive(8'h0F, 1'b1, 1'b0, '0, 44'hABC, 12'hCC1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat);
        check("t4_latency", lat, 2);
        snap = 256'h00000003_00000002_00000001_00000000;
        drive(8'h0F, 1'b0, 1'b1,
              256'h000000B7_000000B6_000000B5_000000B4_000000B3_000000B2_000000B1_000000B0,
              44'hDEF, 12'h340);
        clr_mon();
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_valid", rsp_valid, 1'b1);
            check("t4_stall_data", rsp_data, snap);
            check("t4_stall_uuid", rsp_uuid, 44'hABC);
            check("t4_stall_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        check("t4_stall_strobes", n_rd + n_wr, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t4_hs_rsp_valid", rsp_valid, 1'b0);
        check("t4_hs_req_ready", req_ready, 1'b1);

        // Write-only request accepted on the cycle after the handshake.
        clr_mon();
        @(negedge clk);
        req_valid = 1'b0;
        check("t5_issue", {csr_read_enable, csr_write_enable, csr_pid}, 3'b010);
        wait_rsp(lat);
        check("t5_latency", lat, 2);
        check("t5_n_rd", n_rd, 0);
        check("t5_n_wr", n_wr, 1);
        check("t5_wr_pid", wr_pid, 1'b0);
        check("t5_wr_data", wr_data, 128'h000000B3_000000B2_000000B1_000000B0);
        check("t5_rsp_data", rsp_data, '0);
        check("t5_rsp_uuid", rsp_uuid, 44'hDEF);
        finish_rsp();

        // Reset asserted in the middle of an issue sequence.
        clr_mon();
        drive(8'hFF, 1'b1, 1'b1, '1, 44'h777, 12'hCC0);
        @(negedge clk);
        req_valid = 1'b0;
        check("t6_in_issue", {csr_read_enable, csr_write_enable, csr_pid}, 3'b110);
        reset_n = 1'b0;
        #1;
        check("t6_rst_strobes", {csr_read_enable, csr_write_enable}, 2'b00);
        check("t6_rst_rsp_valid", rsp_valid, 1'b0);
        check("t6_rst_csr_tmask", csr_tmask, 4'h0);
        check("t6_rst_csr_wdata", csr_write_data, '0);
        check("t6_rst_csr_uuid", csr_uuid, 44'h0);
        check("t6_rst_rsp_data", rsp_data, '0);
        @(negedge clk);
        clr_mon();
        reset_n = 1'b1;
        @(negedge clk);
        check("t6_req_ready", req_ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("t6_no_rsp", rsp_valid, 1'b0);
        end
        check("t6_no_strobes", n_rd + n_wr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
